// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default sizes for the pipeline stage latch
package pipe_pkg;

    localparam int DEF_DW  = 16;
    localparam int DEF_NCH = 3;

    // Encoding equals the number of held entries, so occ is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/pipe_stage_latch_reg.sv
// rtl/pipe_stage_latch_reg.sv - write-enabled register with asynchronous reset value
module pipe_stage_latch_reg #(
    parameter int           W    = 48,
    parameter logic [W-1:0] RSTV = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RSTV;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_latch.sv
// rtl/pipe_stage_latch.sv - two-entry skid latch between pipeline stages with flush and stall counter
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int            DW     = DEF_DW,
    parameter int            NCH    = DEF_NCH,
    parameter logic [DW-1:0] RSTVAL = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic [1:0]        occ,
    output logic [15:0]       stall_cnt
);

    localparam int                W      = NCH * DW;
    localparam logic [W-1:0]      RSTREP = {NCH{RSTVAL}};

    state_t         state;
    state_t         state_nx;
    logic           in_ready_q;
    logic           accept;
    logic           pop;
    logic           main_we;
    logic           skid_we;
    logic [W-1:0]   main_d;
    logic [W-1:0]   main_q;
    logic [W-1:0]   skid_q;
    logic [15:0]    stall_q;

    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign occ       = state;
    assign stall_cnt = stall_q;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        main_we  = 1'b0;
        skid_we  = 1'b0;
        main_d   = in_data;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nx = ST_ONE;
                    main_we  = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_we = 1'b1;
                end else if (accept) begin
                    state_nx = ST_TWO;
                    skid_we  = 1'b1;
                end else if (pop) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_nx = ST_ONE;
                    main_we  = 1'b1;
                    main_d   = skid_q;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
        // Squash wins over everything; held data is left in place, only validity drops.
        if (flush) begin
            state_nx = ST_EMPTY;
            main_we  = 1'b0;
            skid_we  = 1'b0;
        end
    end

    // Registered ready keeps out_ready off the upstream timing path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_nx != ST_TWO);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'h0000;
        end else if (flush) begin
            stall_q <= 16'h0000;
        end else if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    pipe_stage_latch_reg #(
        .W    (W),
        .RSTV (RSTREP)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .we  (main_we),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_stage_latch_reg #(
        .W    (W),
        .RSTV (RSTREP)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .we  (skid_we),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb/tb_pipe_stage_latch.sv - self-checking bench for pipe_stage_latch against a queue model
module tb_pipe_stage_latch;

    localparam int           DW     = 16;
    localparam int           NCH    = 3;
    localparam int           W      = DW * NCH;
    localparam logic [15:0]  RV     = 16'hC3A5;
    localparam logic [W-1:0] RSTREP = {NCH{RV}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occ;
    logic [15:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_q[$];
    logic [W-1:0] m_main;
    int           m_stall;

    logic [W-1:0] val_a;
    logic [W-1:0] val_b;
    logic [W-1:0] val_c;

    pipe_stage_latch #(
        .DW     (DW),
        .NCH    (NCH),
        .RSTVAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_main  = RSTREP;
        m_stall = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit pp;
        acc = in_valid && (m_q.size() < 2);
        pp  = (m_q.size() > 0) && out_ready;
        if (flush) begin
            m_q.delete();
            m_stall = 0;
        end else begin
            if ((m_q.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
            if (pp) void'(m_q.pop_front());
            if (acc) m_q.push_back(in_data);
        end
        if (m_q.size() > 0) m_main = m_q[0];
    endtask

    task automatic check_all();
        chk_eq("in_ready",  64'(in_ready),  64'(m_q.size() < 2));
        chk_eq("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        chk_eq("occ",       64'(occ),       64'(m_q.size()));
        chk_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk_eq("out_data",  64'(out_data),  64'(m_main));
    endtask

    task automatic tick(input bit do_chk);
        if (do_chk) check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        val_a = {NCH{16'hAAAA}};
        val_b = {NCH{16'hBBBB}};
        val_c = {NCH{16'h1234}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        chk_eq("rst_out_data", 64'(out_data), 64'(RSTREP));
        rst = 1'b0;

        // First accept right after reset release, one-cycle latency
        in_valid  = 1'b1;
        in_data   = {16'h0003, 16'h0002, 16'h0001};
        out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk_eq("lat1_valid", 64'(out_valid), 64'd1);
        chk_eq("lat1_data",  64'(out_data),  64'h0003_0002_0001);
        chk_eq("lat1_occ",   64'(occ),       64'd1);

        // Simultaneous accept and pop in ONE
        in_valid = 1'b1;
        in_data  = val_c;
        tick(1);
        in_valid = 1'b0;
        chk_eq("thru_occ",  64'(occ),      64'd1);
        chk_eq("thru_data", 64'(out_data), 64'(val_c));
        tick(1);

        // Fill to TWO under backpressure, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = val_a;
        tick(1);
        in_data = val_b;
        tick(1);
        in_valid = 1'b0;
        chk_eq("full_occ",   64'(occ),      64'd2);
        chk_eq("full_ready", 64'(in_ready), 64'd0);
        chk_eq("full_data",  64'(out_data), 64'(val_a));
        tick(1);
        tick(1);
        chk_eq("hold_data", 64'(out_data), 64'(val_a));
        out_ready = 1'b1;
        tick(1);
        chk_eq("drain_b", 64'(out_data), 64'(val_b));
        tick(1);
        chk_eq("drain_occ", 64'(occ), 64'd0);

        // Flush dominates a same-cycle push while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = val_a;
        tick(1);
        in_data = val_b;
        tick(1);
        flush   = 1'b1;
        in_data = val_c;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_eq("flush_valid", 64'(out_valid), 64'd0);
        chk_eq("flush_occ",   64'(occ),       64'd0);
        chk_eq("flush_ready", 64'(in_ready),  64'd1);
        chk_eq("flush_stall", 64'(stall_cnt), 64'd0);
        tick(1);

        // Randomised traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = W'({$urandom(), $urandom()});
            tick(1);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        check_all();

        // Asynchronous reset between edges while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = val_a;
        tick(1);
        in_data = val_b;
        tick(1);
        in_valid = 1'b0;
        chk_eq("pre_arst_occ", 64'(occ), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_eq("arst_valid", 64'(out_valid), 64'd0);
        chk_eq("arst_occ",   64'(occ),       64'd0);
        chk_eq("arst_data",  64'(out_data),  64'(RSTREP));
        chk_eq("arst_ready", 64'(in_ready),  64'd1);
        #1;
        rst = 1'b0;

        // Stall counter saturation
        in_valid = 1'b1;
        in_data  = val_c;
        tick(1);
        in_valid = 1'b0;
        repeat (70000) tick(0);
        chk_eq("stall_sat", 64'(stall_cnt), 64'hFFFF);
        repeat (5) tick(1);
        chk_eq("stall_hold", 64'(stall_cnt), 64'hFFFF);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_latch.md
PIPE_STAGE_LATCH -- requirements
Module: pipe_stage_latch

Interface
REQ-001 SHALL have parameter DW, default 16, data width per channel in bits.
REQ-002 SHALL have parameter NCH, default 3, channel count (ALU, PC, readData for the WB stage).
REQ-003 SHALL have parameter RSTVAL, default 16'h0000, reset value loaded into every channel of both entries.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream stage offers in_data.
REQ-007 SHALL have port in_ready  output  1  latch can accept, registered.
REQ-008 SHALL have port in_data  input  NCH*DW  channel k at bits [k*DW +: DW].
REQ-009 SHALL have port flush  input  1  synchronous squash of all held entries.
REQ-010 SHALL have port out_valid  output  1  out_data holds a live entry.
REQ-011 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-012 SHALL have port out_data  output  NCH*DW  oldest held entry, same packing as in_data.
REQ-013 SHALL have port occ  output  2  entries held, 0..2.
REQ-014 SHALL have port stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 SHALL accept when in_valid and in_ready are both 1; SHALL pop when out_valid and out_ready are both 1.
REQ-016 SHALL hold entries in a 2-entry skid structure: MAIN (drives out_data) and SKID.
REQ-017 SHALL implement states EMPTY (occ=0), ONE (occ=1), TWO (occ=2).
REQ-018 EMPTY + accept -> ONE, data into MAIN, out_valid=1 next cycle; latency in->out is exactly 1 cycle.
REQ-019 ONE + accept + pop -> ONE, MAIN loads new data.
REQ-020 ONE + accept, no pop -> TWO, data into SKID.
REQ-021 ONE + pop, no accept -> EMPTY.
REQ-022 TWO + pop -> ONE, SKID moves to MAIN; accept is impossible in TWO.
REQ-023 in_ready SHALL be 0 in TWO and 1 otherwise, taken from registered state with no combinational path from out_ready.
REQ-024 SHALL deliver entries in strict acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-025 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL dominate accept and pop in the same cycle: next state EMPTY and out_valid=0; data registers keep their contents; stall_cnt is cleared.
REQ-027 stall_cnt SHALL saturate at 16'hFFFF without wrapping.
REQ-028 out_data SHALL be the MAIN contents regardless of out_valid; consumers qualify it with out_valid.

Reset
REQ-029 While rst=1, outputs SHALL be: out_valid=0, occ=0, in_ready=1, stall_cnt=0, MAIN=SKID=RSTVAL on every channel, and out_data=RSTVAL replicated.
REQ-030 rst asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 State encoding (EMPTY/ONE/TWO) and the default DW/NCH SHALL live in shared package pipe_pkg.
REQ-033 Each entry SHALL be built from the existing register sub-module (one NCH*DW-wide instance per entry, we-driven); no other sub-modules.
REQ-034 RTL SHALL be 120-400 lines with no latches or combinational loops.

Verification
REQ-035 Bench SHALL cover: reset then in_valid=1, in_data={16'h0003,16'h0002,16'h0001}, out_ready=1 -> out_valid=1 next cycle with identical out_data, occ=1.
REQ-036 Bench SHALL cover: out_ready=0, push A=16'hAAAA then B=16'hBBBB -> occ=2, in_ready=0, out_data=A stable; then out_ready=1 -> A then B on consecutive cycles, occ ends 0.
REQ-037 Bench SHALL cover: occ=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, occ=0, in_ready=1, stall_cnt=0, new data dropped.
REQ-038 Bench SHALL cover: ONE state, accept C=16'h1234 and pop simultaneously -> occ stays 1, out_data=C next cycle.
REQ-039 Bench SHALL cover: out_ready=0 with entry held for 70000 cycles -> stall_cnt=16'hFFFF and holds.
REQ-040 Bench SHALL cover: rst pulsed asynchronously between edges while occ=2 -> out_valid=0, occ=0, and out_data=RSTVAL without waiting for a clock edge.
